// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder and its timer:
//   - default RAM and MMIO byte bases
//   - MMIO register byte offsets inside the 32-byte register window
//   - CTRL and STATUS bit indices
//   - timer FSM state encoding
// The CPU test programs use the same offsets and bit positions.
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 11;
  localparam logic [31:0] DEF_DMEM_BASE  = 32'h1001_0000;
  localparam logic [31:0] DEF_MMIO_BASE  = 32'h1002_0000;

  // MMIO byte offsets (low five address bits)
  localparam logic [4:0] OFF_LED       = 5'h00;
  localparam logic [4:0] OFF_CYCLE     = 5'h04;
  localparam logic [4:0] OFF_TIMER_CNT = 5'h08;
  localparam logic [4:0] OFF_TIMER_CMP = 5'h0C;
  localparam logic [4:0] OFF_CTRL      = 5'h10;
  localparam logic [4:0] OFF_STATUS    = 5'h14;
  localparam logic [4:0] OFF_ERR_ADDR  = 5'h18;
  localparam logic [4:0] OFF_RSVD      = 5'h1C;

  // CTRL bits
  localparam int CTRL_EN_BIT         = 0;
  localparam int CTRL_AUTORELOAD_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT     = 2;

  // STATUS bits
  localparam int STATUS_MATCH_BIT = 0;
  localparam int STATUS_ERR_BIT   = 1;

  typedef enum logic {
    TIMER_IDLE = 1'b0,
    TIMER_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/dmem_timer.sv
// ---------------------------------------------------------------------------
// dmem_timer
// Compare timer behind the MMIO block. Holds TIMER_CNT, TIMER_CMP, the CTRL
// bits and the sticky match flag. CTRL.en is not stored separately: it is the
// FSM state itself (IDLE = disabled, RUN = counting).
// Ports:
//   clk          CPU clock
//   rst          synchronous reset, active-low
//   wr_cnt_i     CPU write strobe for TIMER_CNT
//   wr_cmp_i     CPU write strobe for TIMER_CMP
//   wr_ctrl_i    CPU write strobe for CTRL
//   clr_match_i  W1C clear of STATUS.match
//   wdata_i      CPU write data
//   cnt_o        current TIMER_CNT
//   cmp_o        current TIMER_CMP
//   ctrl_o       {irq_en, autoreload, en}
//   match_o      sticky STATUS.match
// ---------------------------------------------------------------------------
module dmem_timer
  import dmem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_cnt_i,
  input  logic        wr_cmp_i,
  input  logic        wr_ctrl_i,
  input  logic        clr_match_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] cnt_o,
  output logic [31:0] cmp_o,
  output logic [2:0]  ctrl_o,
  output logic        match_o
);

  timer_state_e state_q, state_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  cmp_q, cmp_d;
  logic         autoreload_q, autoreload_d;
  logic         irq_en_q, irq_en_d;
  logic         match_q, match_d;
  logic         match_set;

  // Timer's own update first, then CPU writes override it so software
  // always wins over the hardware in the same cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmp_d        = cmp_q;
    autoreload_d = autoreload_q;
    irq_en_d     = irq_en_q;
    match_set    = 1'b0;

    if (state_q == TIMER_RUN) begin
      if (cnt_q != cmp_q) begin
        cnt_d = cnt_q + 32'd1;
      end else begin
        match_set = 1'b1;
        if (autoreload_q) begin
          cnt_d = 32'd0;
        end else begin
          state_d = TIMER_IDLE;
        end
      end
    end

    if (wr_cnt_i) begin
      cnt_d = wdata_i;
    end
    if (wr_cmp_i) begin
      cmp_d = wdata_i;
    end
    if (wr_ctrl_i) begin
      state_d      = wdata_i[CTRL_EN_BIT] ? TIMER_RUN : TIMER_IDLE;
      autoreload_d = wdata_i[CTRL_AUTORELOAD_BIT];
      irq_en_d     = wdata_i[CTRL_IRQ_EN_BIT];
    end

    // a hardware match in the same cycle outranks the W1C clear
    match_d = match_set | (match_q & ~clr_match_i);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= TIMER_IDLE;
      cnt_q        <= 32'd0;
      cmp_q        <= 32'd0;
      autoreload_q <= 1'b0;
      irq_en_q     <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmp_q        <= cmp_d;
      autoreload_q <= autoreload_d;
      irq_en_q     <= irq_en_d;
      match_q      <= match_d;
    end
  end

  always_comb begin
    ctrl_o                      = 3'b000;
    ctrl_o[CTRL_EN_BIT]         = (state_q == TIMER_RUN);
    ctrl_o[CTRL_AUTORELOAD_BIT] = autoreload_q;
    ctrl_o[CTRL_IRQ_EN_BIT]     = irq_en_q;
  end

  assign cnt_o   = cnt_q;
  assign cmp_o   = cmp_q;
  assign match_o = match_q;

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Responder end of the single-cycle CPU's data-memory port. Decodes the byte
// address into word RAM, the MMIO register block or unmapped space, returns
// read data combinationally and commits writes at the next rising edge.
// Bad accesses (misaligned, unmapped, read+write together, write to the
// reserved slot) set a sticky error flag and record the first bad address.
// Ports:
//   clk         CPU clock
//   rst         synchronous reset, active-low
//   dmem_ena    access valid
//   dmem_w      write request
//   dmem_r      read request
//   dmem_addr   byte address
//   dmem_wdata  write data
//   dmem_rdata  read data, zero-latency, 0 when not a valid read
//   led_o       LED register
//   irq_o       timer interrupt (STATUS.match & CTRL.irq_en)
//   err_o       sticky error (STATUS.err)
// ---------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [31:0] DMEM_BASE  = DEF_DMEM_BASE,
  parameter logic [31:0] MMIO_BASE  = DEF_MMIO_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_ena,
  input  logic        dmem_w,
  input  logic        dmem_r,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic [15:0] led_o,
  output logic        irq_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem_q [DEPTH];

  logic [15:0] led_q, led_d;
  logic [31:0] cycle_q, cycle_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [4:0]  mmio_off;
  logic        aligned, ram_hit, mmio_hit, rsvd_hit;
  logic        rd_ok, wr_ok, err_ev;
  logic        wr_ram, wr_led, wr_cnt, wr_cmp, wr_ctrl, wr_status;

  logic [31:0] t_cnt, t_cmp;
  logic [2:0]  t_ctrl;
  logic        t_match;
  logic [31:0] status_rd;

  // Address decode. DMEM_BASE is aligned to the RAM size, so the RAM hit is
  // a compare of the bits above the word index.
  assign ram_idx  = dmem_addr[ADDR_WIDTH+1:2];
  assign mmio_off = dmem_addr[4:0];
  assign aligned  = (dmem_addr[1:0] == 2'b00);
  assign ram_hit  = (dmem_addr[31:ADDR_WIDTH+2] == DMEM_BASE[31:ADDR_WIDTH+2]);
  assign mmio_hit = (dmem_addr[31:5] == MMIO_BASE[31:5]);
  assign rsvd_hit = mmio_hit && (mmio_off == OFF_RSVD);

  // The reserved slot is readable (as 0) but not writable. Writes are
  // gated by reset so a write presented during a reset cycle is dropped.
  assign rd_ok  = dmem_ena & dmem_r & ~dmem_w & aligned & (ram_hit | mmio_hit);
  assign wr_ok  = rst & dmem_ena & dmem_w & ~dmem_r & aligned
                & (ram_hit | (mmio_hit & ~rsvd_hit));
  assign err_ev = dmem_ena & (~aligned | ~(ram_hit | mmio_hit)
                | (dmem_r & dmem_w) | (dmem_w & rsvd_hit));

  assign wr_ram    = wr_ok & ram_hit;
  assign wr_led    = wr_ok & mmio_hit & (mmio_off == OFF_LED);
  assign wr_cnt    = wr_ok & mmio_hit & (mmio_off == OFF_TIMER_CNT);
  assign wr_cmp    = wr_ok & mmio_hit & (mmio_off == OFF_TIMER_CMP);
  assign wr_ctrl   = wr_ok & mmio_hit & (mmio_off == OFF_CTRL);
  assign wr_status = wr_ok & mmio_hit & (mmio_off == OFF_STATUS);

  dmem_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .wr_cnt_i    (wr_cnt),
    .wr_cmp_i    (wr_cmp),
    .wr_ctrl_i   (wr_ctrl),
    .clr_match_i (wr_status & dmem_wdata[STATUS_MATCH_BIT]),
    .wdata_i     (dmem_wdata),
    .cnt_o       (t_cnt),
    .cmp_o       (t_cmp),
    .ctrl_o      (t_ctrl),
    .match_o     (t_match)
  );

  // RAM contents survive reset; only the write path is reset-gated.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      mem_q[ram_idx] <= dmem_wdata;
    end
  end

  // ERR_ADDR only latches the first bad address after err was clear; a new
  // error outranks a simultaneous W1C of the err bit.
  always_comb begin
    led_d      = wr_led ? dmem_wdata[15:0] : led_q;
    cycle_d    = cycle_q + 32'd1;
    err_d      = err_ev | (err_q & ~(wr_status & dmem_wdata[STATUS_ERR_BIT]));
    err_addr_d = (err_ev && !err_q) ? dmem_addr : err_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q      <= 16'd0;
      cycle_q    <= 32'd0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      led_q      <= led_d;
      cycle_q    <= cycle_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    status_rd                   = 32'd0;
    status_rd[STATUS_MATCH_BIT] = t_match;
    status_rd[STATUS_ERR_BIT]   = err_q;
  end

  // Read mux; CYCLE returns the value before this edge's increment.
  always_comb begin
    dmem_rdata = 32'd0;
    if (rd_ok) begin
      if (ram_hit) begin
        dmem_rdata = mem_q[ram_idx];
      end else begin
        case (mmio_off)
          OFF_LED:       dmem_rdata = {16'd0, led_q};
          OFF_CYCLE:     dmem_rdata = cycle_q;
          OFF_TIMER_CNT: dmem_rdata = t_cnt;
          OFF_TIMER_CMP: dmem_rdata = t_cmp;
          OFF_CTRL:      dmem_rdata = {29'd0, t_ctrl};
          OFF_STATUS:    dmem_rdata = status_rd;
          OFF_ERR_ADDR:  dmem_rdata = err_addr_q;
          default:       dmem_rdata = 32'd0;
        endcase
      end
    end
  end

  assign led_o = led_q;
  assign irq_o = t_match & t_ctrl[CTRL_IRQ_EN_BIT];
  assign err_o = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for the data-memory responder: reset state, RAM path, error
// capture, one-shot and autoreload timer, LED/CYCLE and reset mid-run.
// Inputs change on the falling edge; outputs are sampled #1 after it (for
// combinational read data) or #1 after the rising edge (for state).
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dmem_ena = 1'b0;
  logic        dmem_w = 1'b0;
  logic        dmem_r = 1'b0;
  logic [31:0] dmem_addr = 32'd0;
  logic [31:0] dmem_wdata = 32'd0;
  logic [31:0] dmem_rdata;
  logic [15:0] led_o;
  logic        irq_o;
  logic        err_o;

  int checks = 0;
  int passes = 0;

  localparam logic [31:0] A_LED    = 32'h1002_0000;
  localparam logic [31:0] A_CYCLE  = 32'h1002_0004;
  localparam logic [31:0] A_CNT    = 32'h1002_0008;
  localparam logic [31:0] A_CMP    = 32'h1002_000C;
  localparam logic [31:0] A_CTRL   = 32'h1002_0010;
  localparam logic [31:0] A_STATUS = 32'h1002_0014;
  localparam logic [31:0] A_ERRA   = 32'h1002_0018;
  localparam logic [31:0] A_RSVD   = 32'h1002_001C;

  dmem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .dmem_ena   (dmem_ena),
    .dmem_w     (dmem_w),
    .dmem_r     (dmem_r),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .led_o      (led_o),
    .irq_o      (irq_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // One write cycle; returns just after the edge that commits it.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    dmem_ena = 1'b1; dmem_w = 1'b1; dmem_r = 1'b0; dmem_addr = a; dmem_wdata = d;
    @(posedge clk); #1;
    dmem_ena = 1'b0; dmem_w = 1'b0;
  endtask

  // One read cycle; data sampled mid-cycle, returns just after the edge.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    dmem_ena = 1'b1; dmem_r = 1'b1; dmem_w = 1'b0; dmem_addr = a;
    #1 d = dmem_rdata;
    @(posedge clk); #1;
    dmem_ena = 1'b0; dmem_r = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic [31:0] regs [6];
    regs = '{A_LED, A_CNT, A_CMP, A_CTRL, A_STATUS, A_ERRA};
    $display("[TB] test_reset");
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    checks++; if (led_o !== 16'h0) $display("[TB] FAIL reset_led got %h exp 0", led_o); else passes++;
    checks++; if (irq_o !== 1'b0) $display("[TB] FAIL reset_irq got %b exp 0", irq_o); else passes++;
    checks++; if (err_o !== 1'b0) $display("[TB] FAIL reset_err got %b exp 0", err_o); else passes++;
    for (int i = 0; i < 6; i++) begin
      bus_read(regs[i], d);
      checks++; if (d !== 32'h0) $display("[TB] FAIL reset_reg[%0h] got %h exp 0", regs[i], d); else passes++;
    end
    bus_read(A_RSVD, d);
    checks++; if (d !== 32'h0) $display("[TB] FAIL reset_rsvd got %h exp 0", d); else passes++;
  endtask

  task automatic test_ram;
    logic [31:0] d;
    $display("[TB] test_ram");
    bus_write(32'h1001_0004, 32'hDEAD_BEEF);
    bus_read(32'h1001_0004, d);
    checks++; if (d !== 32'hDEAD_BEEF) $display("[TB] FAIL ram_rd4 got %h exp deadbeef", d); else passes++;
    bus_write(32'h1001_1FFC, 32'h0BAD_F00D);
    bus_read(32'h1001_1FFC, d);
    checks++; if (d !== 32'h0BAD_F00D) $display("[TB] FAIL ram_last got %h exp 0badf00d", d); else passes++;
    bus_read(32'h1001_0008, d);
    checks++; if (err_o !== 1'b0) $display("[TB] FAIL ram_unwritten_err got %b exp 0", err_o); else passes++;
  endtask

  task automatic test_errors;
    logic [31:0] d;
    $display("[TB] test_errors");
    bus_read(32'h1001_0002, d);
    checks++; if (d !== 32'h0) $display("[TB] FAIL misalign_rdata got %h exp 0", d); else passes++;
    checks++; if (err_o !== 1'b1) $display("[TB] FAIL misalign_err got %b exp 1", err_o); else passes++;
    bus_read(A_ERRA, d);
    checks++; if (d !== 32'h1001_0002) $display("[TB] FAIL err_addr got %h exp 10010002", d); else passes++;
    bus_write(32'h0000_0000, 32'h0);
    bus_read(A_ERRA, d);
    checks++; if (d !== 32'h1001_0002) $display("[TB] FAIL err_addr_hold got %h exp 10010002", d); else passes++;
    bus_write(A_STATUS, 32'h2);
    checks++; if (err_o !== 1'b0) $display("[TB] FAIL w1c_err got %b exp 0", err_o); else passes++;

    // read and write together on a valid RAM address
    @(negedge clk);
    dmem_ena = 1'b1; dmem_r = 1'b1; dmem_w = 1'b1;
    dmem_addr = 32'h1001_0004; dmem_wdata = 32'h1111_1111;
    #1 d = dmem_rdata;
    @(posedge clk); #1;
    dmem_ena = 1'b0; dmem_r = 1'b0; dmem_w = 1'b0;
    checks++; if (d !== 32'h0) $display("[TB] FAIL rw_rdata got %h exp 0", d); else passes++;
    checks++; if (err_o !== 1'b1) $display("[TB] FAIL rw_err got %b exp 1", err_o); else passes++;
    bus_read(A_ERRA, d);
    checks++; if (d !== 32'h1001_0004) $display("[TB] FAIL rw_err_addr got %h exp 10010004", d); else passes++;
    bus_read(32'h1001_0004, d);
    checks++; if (d !== 32'hDEAD_BEEF) $display("[TB] FAIL rw_no_write got %h exp deadbeef", d); else passes++;
    bus_write(A_STATUS, 32'h2);

    bus_write(A_RSVD, 32'h5);
    checks++; if (err_o !== 1'b1) $display("[TB] FAIL rsvd_wr_err got %b exp 1", err_o); else passes++;
    bus_write(A_STATUS, 32'h2);
    bus_read(A_RSVD, d);
    checks++; if (d !== 32'h0) $display("[TB] FAIL rsvd_rd got %h exp 0", d); else passes++;
    checks++; if (err_o !== 1'b0) $display("[TB] FAIL rsvd_rd_err got %b exp 0", err_o); else passes++;
  endtask

  task automatic test_oneshot;
    logic [31:0] d;
    $display("[TB] test_oneshot");
    bus_write(A_CMP, 32'd5);
    bus_write(A_CTRL, 32'b101);
    idle(5);
    checks++; if (irq_o !== 1'b0) $display("[TB] FAIL oneshot_early_irq got %b exp 0", irq_o); else passes++;
    idle(1);
    checks++; if (irq_o !== 1'b1) $display("[TB] FAIL oneshot_irq got %b exp 1", irq_o); else passes++;
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h1) $display("[TB] FAIL oneshot_status got %h exp 1", d); else passes++;
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h4) $display("[TB] FAIL oneshot_ctrl got %h exp 4", d); else passes++;
    bus_read(A_CNT, d);
    checks++; if (d !== 32'd5) $display("[TB] FAIL oneshot_cnt got %h exp 5", d); else passes++;
    bus_write(A_STATUS, 32'h1);
    checks++; if (irq_o !== 1'b0) $display("[TB] FAIL oneshot_clr_irq got %b exp 0", irq_o); else passes++;
  endtask

  task automatic test_autoreload;
    logic [31:0] d;
    logic [31:0] exp_cnt [8];
    exp_cnt = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2, 32'd3};
    $display("[TB] test_autoreload");
    bus_write(A_CNT, 32'd0);
    bus_write(A_CMP, 32'd3);
    bus_write(A_CTRL, 32'b011);
    for (int i = 0; i < 8; i++) begin
      bus_read(A_CNT, d);
      checks++; if (d !== exp_cnt[i]) $display("[TB] FAIL auto_cnt[%0d] got %h exp %h", i, d, exp_cnt[i]); else passes++;
    end
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h1) $display("[TB] FAIL auto_match got %h exp 1", d); else passes++;
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h0) $display("[TB] FAIL auto_w1c got %h exp 0", d); else passes++;
    // this clear lands on the same edge that re-sets match
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h1) $display("[TB] FAIL auto_set_beats_clr got %h exp 1", d); else passes++;
    checks++; if (irq_o !== 1'b0) $display("[TB] FAIL auto_irq_masked got %b exp 0", irq_o); else passes++;
    bus_write(A_CTRL, 32'h0);
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h0) $display("[TB] FAIL auto_cleanup got %h exp 0", d); else passes++;
  endtask

  task automatic test_led_cycle;
    logic [31:0] d, c1, c2, c3;
    $display("[TB] test_led_cycle");
    bus_write(A_LED, 32'h1234_ABCD);
    checks++; if (led_o !== 16'hABCD) $display("[TB] FAIL led_o got %h exp abcd", led_o); else passes++;
    bus_read(A_LED, d);
    checks++; if (d !== 32'h0000_ABCD) $display("[TB] FAIL led_rd got %h exp 0000abcd", d); else passes++;
    bus_read(A_CYCLE, c1);
    idle(4);
    bus_read(A_CYCLE, c2);
    checks++; if (c2 - c1 !== 32'd5) $display("[TB] FAIL cycle_delta got %0d exp 5", c2 - c1); else passes++;
    bus_write(A_CYCLE, 32'h0);
    checks++; if (err_o !== 1'b0) $display("[TB] FAIL cycle_wr_err got %b exp 0", err_o); else passes++;
    bus_read(A_CYCLE, c3);
    checks++; if (c3 - c2 !== 32'd2) $display("[TB] FAIL cycle_wr_ignored got %0d exp 2", c3 - c2); else passes++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic [31:0] regs [6];
    regs = '{A_LED, A_CNT, A_CMP, A_CTRL, A_STATUS, A_ERRA};
    $display("[TB] test_reset_mid");
    bus_write(32'h1001_0010, 32'hCAFE_F00D);
    bus_write(A_LED, 32'hFFFF);
    bus_write(A_CMP, 32'd2);
    bus_write(A_CTRL, 32'b111);
    bus_read(32'h0000_0004, d);
    idle(3);
    checks++; if (irq_o !== 1'b1) $display("[TB] FAIL pre_reset_irq got %b exp 1", irq_o); else passes++;
    checks++; if (err_o !== 1'b1) $display("[TB] FAIL pre_reset_err got %b exp 1", err_o); else passes++;
    @(negedge clk);
    rst = 1'b0;
    dmem_ena = 1'b1; dmem_w = 1'b1; dmem_r = 1'b0;
    dmem_addr = 32'h1001_0010; dmem_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    rst = 1'b1; dmem_ena = 1'b0; dmem_w = 1'b0;
    checks++; if (irq_o !== 1'b0) $display("[TB] FAIL mid_irq got %b exp 0", irq_o); else passes++;
    checks++; if (led_o !== 16'h0) $display("[TB] FAIL mid_led got %h exp 0", led_o); else passes++;
    checks++; if (err_o !== 1'b0) $display("[TB] FAIL mid_err got %b exp 0", err_o); else passes++;
    bus_read(A_CYCLE, d);
    checks++; if (d !== 32'h0) $display("[TB] FAIL mid_cycle got %h exp 0", d); else passes++;
    for (int i = 0; i < 6; i++) begin
      bus_read(regs[i], d);
      checks++; if (d !== 32'h0) $display("[TB] FAIL mid_reg[%0h] got %h exp 0", regs[i], d); else passes++;
    end
    bus_read(32'h1001_0010, d);
    checks++; if (d !== 32'hCAFE_F00D) $display("[TB] FAIL mid_ram_kept got %h exp cafef00d", d); else passes++;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_errors();
    test_oneshot();
    test_autoreload();
    test_led_cycle();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired after %0d of %0d checks", passes, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
